// File: rtl/seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// seq_shift_add_multiplier
//
// Iterative shift-add multiplier producing a full 2*WIDTH-bit product from two
// WIDTH-bit operands. It supports unsigned operands and, when SIGNED_EN is set,
// two's-complement operands selected per operation by is_signed.
//
// The engine multiplies operand magnitudes and applies the sign only at the
// end. The smaller magnitude becomes the multiplier, so the iteration count
// equals that operand's bit length. The operation finishes as soon as the
// remaining multiplier bits are all zero.
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset; aborts any operation in flight
//   S          start, sampled only while busy = 0
//   is_signed  operand mode, sampled with S (1 = two's complement)
//   in1, in2   WIDTH-bit operands, sampled with S
//   busy       high while an operation is in flight
//   V          one-cycle pulse: data_out holds a new product
//   data_out   2*WIDTH-bit product, held until the next product is written
// -----------------------------------------------------------------------------
module seq_shift_add_multiplier #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 S,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 busy,
  output logic                 V,
  output logic [2*WIDTH-1:0]   data_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state;
  logic [WIDTH-1:0]   mult;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic               neg;

  logic               signed_mode;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   mult_init;
  logic [WIDTH-1:0]   mcand_init;

  assign signed_mode = SIGNED_EN && is_signed;

  // Operand magnitudes and ordering are computed from the live inputs. They
  // are captured only on the edge that accepts S.
  // NOTE: every always_comb output is assigned a default first. If any path
  // leaves an output unassigned, synthesis infers a latch.
  always_comb begin
    abs_a      = in1;
    abs_b      = in2;
    // Negating in WIDTH bits maps -2^(WIDTH-1) onto itself. Read as unsigned,
    // that value is the correct magnitude 2^(WIDTH-1).
    if (signed_mode && in1[WIDTH-1]) abs_a = -in1;
    if (signed_mode && in2[WIDTH-1]) abs_b = -in2;
    mult_init  = abs_a;
    mcand_init = abs_b;
    if (abs_b < abs_a) begin
      mult_init  = abs_b;
      mcand_init = abs_a;
    end
  end

  assign busy = (state == RUN);

  // NOTE: state is updated with non-blocking assignments, so every register
  // sees the pre-edge values of the others. This keeps acc, mcand and mult
  // in step within an iteration.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mult     <= '0;
      mcand    <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      V        <= 1'b0;
      data_out <= '0;
    end else begin
      V <= 1'b0;
      case (state)
        IDLE: begin
          if (S) begin
            neg   <= signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
            mult  <= mult_init;
            mcand <= {{WIDTH{1'b0}}, mcand_init};
            acc   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (mult != '0) begin
            if (mult[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            mult  <= mult >> 1;
          end else begin
            // Negating a zero accumulator gives zero, so -0 needs no special case.
            data_out <= neg ? -acc : acc;
            V        <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_add_multiplier
//
// Scoreboard bench for seq_shift_add_multiplier with WIDTH = 32.
//
// The stimulus process computes each expected product and completion edge with
// plain 64-bit arithmetic and queues them. A separate monitor pops one entry
// for every V pulse and compares both the product and the completion edge.
// -----------------------------------------------------------------------------
module tb_seq_shift_add_multiplier;

  localparam int W = 32;

  logic            clock;
  logic            reset_n;
  logic            S;
  logic            is_signed;
  logic [W-1:0]    in1;
  logic [W-1:0]    in2;
  logic            busy;
  logic            V;
  logic [2*W-1:0]  data_out;

  typedef struct {
    logic [2*W-1:0] prod;
    int             v_edge;
  } exp_t;

  exp_t sb_q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .S         (S),
    .is_signed (is_signed),
    .in1       (in1),
    .in2       (in2),
    .busy      (busy),
    .V         (V),
    .data_out  (data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the true product of the operands as integers, plus the
  // bit length of the smaller magnitude.
  function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [63:0] p, output int n);
    longint sa, sb;
    longint ma, mb, m;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    p  = 64'(sa * sb);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    m  = (ma < mb) ? ma : mb;
    n  = 0;
    while (m != 0) begin
      n++;
      m = m >> 1;
    end
  endfunction

  // Call at a negedge. The task waits for busy = 0, presents one operation and
  // returns at the negedge right after the sampling edge.
  task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    logic [63:0] p;
    int n;
    exp_t e;
    while (busy && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (busy) check("start_wait_timeout", 64'(busy), 64'd0);
    S         = 1'b1;
    is_signed = sgn;
    in1       = a;
    in2       = b;
    model(sgn, a, b, p, n);
    e.prod   = p;
    e.v_edge = edge_cnt + 1 + n + 1;
    sb_q.push_back(e);
    @(negedge clock);
    S         = 1'b0;
    is_signed = 1'($urandom);
    in1       = $urandom;
    in2       = $urandom;
  endtask

  // Monitor: each V pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && V) begin
      if (sb_q.size() == 0) begin
        check("unexpected_V", 64'(V), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("product", data_out, e.prod);
        check("latency_edge", 64'(edge_cnt), 64'(e.v_edge));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    S         = 1'b0;
    is_signed = 1'b0;
    in1       = '0;
    in2       = '0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_V", 64'(V), 64'd0);
    check("reset_data_out", data_out, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // 6*7: busy high after the sampling edge and three more, V on the fourth.
    start_op(1'b0, 32'd6, 32'd7);
    for (int i = 0; i < 4; i++) begin
      check("busy_during_6x7", 64'(busy), 64'd1);
      @(negedge clock);
    end
    check("busy_after_6x7", 64'(busy), 64'd0);
    check("V_after_6x7", 64'(V), 64'd1);

    start_op(1'b0, 32'd1000, 32'd3);
    start_op(1'b1, 32'hFFFF_FFFB, 32'd7);
    start_op(1'b0, 32'hFFFF_FFFB, 32'd7);
    start_op(1'b1, 32'h8000_0000, 32'h8000_0000);
    start_op(1'b1, 32'd0, 32'hFFFF_FFFF);
    start_op(1'b0, 32'd9, 32'd9);
    start_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start_op(1'b1, 32'h7FFF_FFFF, 32'h8000_0000);

    // Start pulses during a long operation must be ignored.
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      check("busy_before_ignored_S", 64'(busy), 64'd1);
      S   = 1'b1;
      in1 = $urandom;
      in2 = $urandom;
      @(negedge clock);
      S = 1'b0;
      @(negedge clock);
    end

    // Asserting reset in the middle of an operation aborts it.
    start_op(1'b0, 32'd255, 32'd255);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrun_reset_busy", 64'(busy), 64'd0);
    check("midrun_reset_V", 64'(V), 64'd0);
    check("midrun_reset_data_out", data_out, 64'd0);
    sb_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start_op(1'b0, 32'd12, 32'd12);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = ($urandom_range(3) == 0) ? W'($urandom_range(15)) : W'($urandom);
      b = ($urandom_range(3) == 0) ? W'($urandom_range(15)) : W'($urandom);
      start_op(1'($urandom), a, b);
    end

    begin
      int g = 0;
      while (sb_q.size() != 0 && g < 200) begin
        @(negedge clock);
        g++;
      end
    end
    @(negedge clock);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
